// File: rtl/debounce_bank.sv
// ---------------------------------------------------------------------------
// debounce_bank
//   Bank of independent switch/button debouncers with edge pulses and a
//   keyboard-style auto-repeat generator per channel.
//
//   Each channel does the following:
//     1. Synchronizes its raw input through two flops.
//     2. Waits for the synchronized level to disagree with the clean level for
//        DEBOUNCE_CYCLES consecutive cycles before it accepts the new level.
//     3. Emits registered one-cycle rise/fall pulses on clean edges.
//     4. Emits a press pulse on every rise. While the channel is held and
//        repeat_en is set, it also emits a press after REPEAT_DELAY cycles and
//        then one every REPEAT_PERIOD cycles.
//
// Parameters
//   CHANNELS         number of independent channels (1..16)
//   DEBOUNCE_CYCLES  stable cycles needed before clean follows (>=2)
//   REPEAT_DELAY     hold time before the first auto-repeat press (>=2)
//   REPEAT_PERIOD    spacing of subsequent auto-repeat presses (>=2)
//
// Ports
//   clock      sole clock, rising edge
//   reset      synchronous, active-high
//   noisy      raw asynchronous switch levels
//   repeat_en  per-channel auto-repeat enable, sampled every cycle
//   clean      debounced levels
//   rise       one-cycle pulse in the first cycle clean reads 1
//   fall       one-cycle pulse in the first cycle clean reads 0
//   press      one-cycle pulse on rise and on each auto-repeat event
// ---------------------------------------------------------------------------
module debounce_bank #(
  parameter int CHANNELS        = 5,
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int REPEAT_DELAY    = 32500000,
  parameter int REPEAT_PERIOD   = 6500000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] press
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int DELAY_W = $clog2(REPEAT_DELAY);
  localparam int PERIOD_W = $clog2(REPEAT_PERIOD);
  localparam int HOLD_W  = (DELAY_W > PERIOD_W) ? DELAY_W : PERIOD_W;

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan

    logic              sync_meta;
    logic              sync_s;
    logic [DB_W-1:0]   db_cnt;
    logic              clean_q;
    logic              rise_q;
    logic              fall_q;
    logic              press_q;
    logic              load;
    logic              clean_nxt;
    rep_state_t        state_q;
    rep_state_t        state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              press_d;

    // Accept the synchronized level once it has disagreed for the full window.
    // The counter only runs while the levels disagree, so it can never pass
    // DB_LAST.
    assign load      = (sync_s != clean_q) && (db_cnt == DB_LAST);
    assign clean_nxt = load ? sync_s : clean_q;

    // NOTE: registers are updated with non-blocking assignments, so every
    // expression here reads the values from before the edge.
    always_ff @(posedge clock) begin
      if (reset) begin
        sync_meta <= 1'b0;
        sync_s    <= 1'b0;
        db_cnt    <= '0;
        clean_q   <= 1'b0;
        rise_q    <= 1'b0;
        fall_q    <= 1'b0;
      end else begin
        sync_meta <= noisy[i];
        sync_s    <= sync_meta;
        // Any agreeing cycle (or a completed load) restarts the window, so
        // a bounce is discarded no matter how close it came to the limit.
        if ((sync_s == clean_q) || load) begin
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
        clean_q <= clean_nxt;
        rise_q  <= load &  sync_s;
        fall_q  <= load & ~sync_s;
      end
    end

    // Repeat FSM. It moves on the same edge that raises clean, so the hold
    // counter is aligned to the first cycle the rise pulse is visible. Exit
    // checks use clean_nxt so that no press can coincide with a fall.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      press_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load && sync_s) begin
            state_d = DELAY;
            hold_d  = '0;
            press_d = 1'b1;
          end
        end
        DELAY: begin
          if (!clean_nxt || !repeat_en[i]) begin
            state_d = IDLE;
            hold_d  = '0;
          end else if (hold_q == DELAY_LAST) begin
            state_d = REPEAT;
            hold_d  = '0;
            press_d = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        REPEAT: begin
          if (!clean_nxt || !repeat_en[i]) begin
            state_d = IDLE;
            hold_d  = '0;
          end else if (hold_q == PERIOD_LAST) begin
            hold_d  = '0;
            press_d = 1'b1;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
        end
      endcase
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= IDLE;
        hold_q  <= '0;
        press_q <= 1'b0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        press_q <= press_d;
      end
    end

    assign clean[i] = clean_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;
    assign press[i] = press_q;

  end : g_chan

endmodule : debounce_bank

// File: tb/tb_debounce_bank.sv
// ---------------------------------------------------------------------------
// tb_debounce_bank
//   Self-checking bench for debounce_bank (4 channels, DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=20, REPEAT_PERIOD=8). It runs directed scenarios and then a
//   randomized phase.
//
//   Cycle n is the interval after rising edge n. Inputs are applied in that
//   interval, and outputs are sampled 1 time unit after each edge.
//
//   The reference model keeps the full input history and derives each output
//   from it:
//     - clean changes when the synchronized level (the input two cycles
//       earlier) has disagreed with clean for the whole DEBOUNCE window;
//     - press fires on each rise, and then at fixed offsets from that rise for
//       as long as clean and repeat_en have stayed high.
// ---------------------------------------------------------------------------
module tb_debounce_bank;

  localparam int CH   = 4;
  localparam int DB   = 4;
  localparam int RD   = 20;
  localparam int RP   = 8;
  localparam int MAXC = 8192;

  localparam int K_RISE  = 0;
  localparam int K_FALL  = 1;
  localparam int K_PRESS = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [CH-1:0] noisy;
  logic [CH-1:0] repeat_en;
  logic [CH-1:0] clean;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] press;

  always #5 clock = ~clock;

  debounce_bank #(
    .CHANNELS        (CH),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .noisy     (noisy),
    .repeat_en (repeat_en),
    .clean     (clean),
    .rise      (rise),
    .fall      (fall),
    .press     (press)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Input history per cycle and model state.
  logic [CH-1:0] n_hist  [MAXC];
  logic          r_hist  [MAXC];
  logic [CH-1:0] e_hist  [MAXC];
  logic [CH-1:0] m_clean [MAXC];
  int            start_c [CH];
  bit            elig    [CH];

  // Observed pulse events, encoded as channel*65536 + cycle.
  int rise_log[$];
  int fall_log[$];
  int press_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Synchronized level of one channel during cycle m.
  function automatic logic sync_level(input int m, input int ch);
    if (m < 2) return 1'b0;
    if (r_hist[m-1] || r_hist[m-2]) return 1'b0;
    return n_hist[m-2][ch];
  endfunction

  function automatic int ev_count(input int kind, input int ch);
    int q[$];
    int n = 0;
    case (kind)
      K_RISE:  q = rise_log;
      K_FALL:  q = fall_log;
      default: q = press_log;
    endcase
    foreach (q[k]) if (q[k] / 65536 == ch) n++;
    return n;
  endfunction

  function automatic int ev_nth(input int kind, input int ch, input int idx);
    int q[$];
    int n = 0;
    case (kind)
      K_RISE:  q = rise_log;
      K_FALL:  q = fall_log;
      default: q = press_log;
    endcase
    foreach (q[k]) begin
      if (q[k] / 65536 == ch) begin
        if (n == idx) return q[k] % 65536;
        n++;
      end
    end
    return -1;
  endfunction

  // Record this cycle's inputs, advance one edge, then check every output
  // against the model.
  task automatic tick();
    logic [CH-1:0] exp_clean;
    logic [CH-1:0] exp_rise;
    logic [CH-1:0] exp_fall;
    logic [CH-1:0] exp_press;
    n_hist[cyc] = noisy;
    r_hist[cyc] = reset;
    e_hist[cyc] = repeat_en;
    @(posedge clock);
    cyc++;
    #1;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cycle=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    exp_clean = '0;
    exp_rise  = '0;
    exp_fall  = '0;
    exp_press = '0;
    for (int ch = 0; ch < CH; ch++) begin
      logic cur;
      logic nv;
      bit   flip;
      int   d;
      cur = m_clean[cyc-1][ch];
      nv  = cur;
      if (r_hist[cyc-1]) begin
        nv = 1'b0;
      end else if (cyc > DB) begin
        flip = 1'b1;
        for (int m = cyc - DB; m <= cyc - 1; m++)
          if (sync_level(m, ch) == cur) flip = 1'b0;
        for (int m = cyc - DB; m <= cyc - 2; m++)
          if (r_hist[m]) flip = 1'b0;
        if (flip) nv = ~cur;
      end
      exp_clean[ch] = nv;
      exp_rise[ch]  = !r_hist[cyc-1] && nv && !cur;
      exp_fall[ch]  = !r_hist[cyc-1] && !nv && cur;
      if (exp_rise[ch]) begin
        start_c[ch] = cyc;
        elig[ch]    = 1'b1;
      end else if (elig[ch]) begin
        elig[ch] = e_hist[cyc-1][ch] && nv && !r_hist[cyc-1];
      end
      d = cyc - start_c[ch];
      exp_press[ch] = exp_rise[ch] ||
                      (elig[ch] && d >= RD && ((d - RD) % RP) == 0);
    end
    m_clean[cyc] = exp_clean;
    check("clean", 32'(clean), 32'(exp_clean));
    check("rise",  32'(rise),  32'(exp_rise));
    check("fall",  32'(fall),  32'(exp_fall));
    check("press", 32'(press), 32'(exp_press));
    check("rise_and_fall", 32'(rise & fall), 32'd0);
    for (int ch = 0; ch < CH; ch++) begin
      if (rise[ch]  === 1'b1) rise_log.push_back(ch * 65536 + cyc);
      if (fall[ch]  === 1'b1) fall_log.push_back(ch * 65536 + cyc);
      if (press[ch] === 1'b1) press_log.push_back(ch * 65536 + cyc);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_logs();
    rise_log.delete();
    fall_log.delete();
    press_log.delete();
  endtask

  int c0;
  int t0;
  int hold_left [CH];

  initial begin
    for (int k = 0; k < MAXC; k++) begin
      n_hist[k]  = '0;
      r_hist[k]  = 1'b1;
      e_hist[k]  = '0;
      m_clean[k] = '0;
    end
    for (int ch = 0; ch < CH; ch++) begin
      start_c[ch] = 0;
      elig[ch]    = 1'b0;
    end
    reset     = 1'b1;
    noisy     = '0;
    repeat_en = '0;

    // Reset state.
    run(3);
    check("reset_clean", 32'(clean), 32'd0);
    check("reset_press", 32'(press), 32'd0);
    reset = 1'b0;

    // Clean press on channel 0: clean follows 6 cycles after the input edge.
    clear_logs();
    noisy[0] = 1'b1;
    c0 = cyc;
    run(12);
    check("ch0_rise_count",  32'(ev_count(K_RISE, 0)),  32'd1);
    check("ch0_rise_cycle",  32'(ev_nth(K_RISE, 0, 0)), 32'(c0 + 6));
    check("ch0_press_count", 32'(ev_count(K_PRESS, 0)), 32'd1);
    check("ch0_press_cycle", 32'(ev_nth(K_PRESS, 0, 0)), 32'(c0 + 6));
    noisy[0] = 1'b0;
    c0 = cyc;
    run(8);
    check("ch0_fall_cycle", 32'(ev_nth(K_FALL, 0, 0)), 32'(c0 + 6));

    // Bounce on channel 1: high 3, low 1, then held high.
    clear_logs();
    noisy[1] = 1'b1;
    run(3);
    noisy[1] = 1'b0;
    run(1);
    noisy[1] = 1'b1;
    c0 = cyc;
    run(10);
    check("ch1_rise_count", 32'(ev_count(K_RISE, 1)),  32'd1);
    check("ch1_rise_cycle", 32'(ev_nth(K_RISE, 1, 0)), 32'(c0 + 6));
    noisy[1] = 1'b0;
    run(8);

    // Auto-repeat on channel 2. Release is timed so that the fall lands
    // exactly where the next repeat press would have been.
    clear_logs();
    repeat_en[2] = 1'b1;
    noisy[2]     = 1'b1;
    t0 = cyc + 6;
    while (cyc < t0 + 38) tick();
    noisy[2] = 1'b0;
    run(16);
    check("ch2_press_count", 32'(ev_count(K_PRESS, 2)),  32'd4);
    check("ch2_press_0",     32'(ev_nth(K_PRESS, 2, 0)), 32'(t0));
    check("ch2_press_1",     32'(ev_nth(K_PRESS, 2, 1)), 32'(t0 + 20));
    check("ch2_press_2",     32'(ev_nth(K_PRESS, 2, 2)), 32'(t0 + 28));
    check("ch2_press_3",     32'(ev_nth(K_PRESS, 2, 3)), 32'(t0 + 36));
    check("ch2_fall_count",  32'(ev_count(K_FALL, 2)),   32'd1);
    check("ch2_fall_cycle",  32'(ev_nth(K_FALL, 2, 0)),  32'(t0 + 44));
    repeat_en[2] = 1'b0;

    // repeat_en low on channel 3: one press only.
    clear_logs();
    noisy[3] = 1'b1;
    t0 = cyc + 6;
    run(45);
    check("ch3_press_count", 32'(ev_count(K_PRESS, 3)),  32'd1);
    check("ch3_press_cycle", 32'(ev_nth(K_PRESS, 3, 0)), 32'(t0));
    noisy[3] = 1'b0;
    run(8);

    // Reset in the middle of auto-repeat on channel 2.
    clear_logs();
    repeat_en[2] = 1'b1;
    noisy[2]     = 1'b1;
    t0 = cyc + 6;
    while (cyc < t0 + 24) tick();
    reset = 1'b1;
    tick();
    check("rst_clean", 32'(clean), 32'd0);
    check("rst_rise",  32'(rise),  32'd0);
    check("rst_fall",  32'(fall),  32'd0);
    check("rst_press", 32'(press), 32'd0);
    reset = 1'b0;
    while (cyc < t0 + 40) tick();
    check("rst_press_count", 32'(ev_count(K_PRESS, 2)),  32'd3);
    check("rst_press_0",     32'(ev_nth(K_PRESS, 2, 0)), 32'(t0));
    check("rst_press_1",     32'(ev_nth(K_PRESS, 2, 1)), 32'(t0 + 20));
    check("rst_press_2",     32'(ev_nth(K_PRESS, 2, 2)), 32'(t0 + 31));
    check("rst_rise_1",      32'(ev_nth(K_RISE, 2, 1)),  32'(t0 + 31));
    check("rst_fall_count",  32'(ev_count(K_FALL, 2)),   32'd0);
    noisy[2]     = 1'b0;
    repeat_en[2] = 1'b0;
    run(10);

    // Simultaneous rise on every channel.
    clear_logs();
    noisy = '1;
    c0 = cyc;
    run(10);
    for (int ch = 0; ch < CH; ch++) begin
      check("sim_rise_cycle", 32'(ev_nth(K_RISE, ch, 0)), 32'(c0 + 6));
      check("sim_fall_count", 32'(ev_count(K_FALL, ch)),  32'd0);
    end
    noisy = '0;
    run(10);

    // Randomized phase with bounces, long holds, enable toggles and the
    // occasional reset.
    for (int ch = 0; ch < CH; ch++) hold_left[ch] = 1;
    for (int k = 0; k < 2000; k++) begin
      for (int ch = 0; ch < CH; ch++) begin
        hold_left[ch]--;
        if (hold_left[ch] <= 0) begin
          noisy[ch] = ~noisy[ch];
          hold_left[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                      : int'($urandom_range(1, 6));
        end
        if ($urandom_range(0, 99) < 2) repeat_en[ch] = ~repeat_en[ch];
      end
      reset = ($urandom_range(0, 999) < 3);
      tick();
    end
    reset = 1'b0;
    run(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_debounce_bank
